// File: rtl/core_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: word/pointer types, arbiter
// state encoding and the pending-request record held per port.
package core_mem_arbiter_pkg;

  typedef logic [29:0] ptr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  typedef struct packed {
    ptr_t  addr;
    logic  write;
    word_t data;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_NONE = '0;

  // Word pointer to byte address on the external bus.
  function automatic word_t byte_addr(input ptr_t ptr);
    return {ptr, 2'b00};
  endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Avalon-style external memory bus seen by the arbiter: the arbiter is the
// master and drives the command, the memory side returns data and stalls.
interface core_mem_arbiter_if;
  import core_mem_arbiter_pkg::*;

  word_t bus_addr;
  logic  bus_read;
  logic  bus_write;
  word_t bus_wrdata;
  word_t bus_rddata;
  logic  bus_waitrequest;

  modport master (
    output bus_addr,
    output bus_read,
    output bus_write,
    output bus_wrdata,
    input  bus_rddata,
    input  bus_waitrequest
  );

  modport slave (
    input  bus_addr,
    input  bus_read,
    input  bus_write,
    input  bus_wrdata,
    output bus_rddata,
    output bus_waitrequest
  );

endinterface

// File: rtl/core_mem_arbiter_slot.sv
// One pending-request register per requester. The slot stays valid from the
// captured start pulse until its bus transaction completes.
module core_mem_arbiter_slot
  import core_mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     start,
  input  mem_req_t req_in,
  input  logic     clear,
  output logic     cand,
  output mem_req_t cand_req
);

  logic     valid;
  mem_req_t req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      req   <= MEM_REQ_NONE;
    end else if (start && !valid) begin
      valid <= 1'b1;
      req   <= req_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  // A start arriving at this edge is already a candidate for the arbiter.
  assign cand     = valid | start;
  assign cand_req = valid ? req : req_in;

  a_no_start_while_busy : assert property (
    @(posedge clk) disable iff (!rst_n) !(start && valid)
  ) else $error("core_mem_arbiter_slot: start while request pending or granted");

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares the external memory bus between instruction fetch and load/store.
// One transaction at a time; the other port's request is issued back-to-back.
//
//   state     | meaning
//   ARB_IDLE  | no command on the bus, waiting for a start or pending slot
//   ARB_FETCH | fetch command on the bus, held until waitrequest drops
//   ARB_DATA  | load/store command on the bus, held until waitrequest drops
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter bit FAIR       = 1'b1,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       insn_start,
  input  ptr_t                       insn_addr,
  output logic                       insn_ready,
  output word_t                      insn_data,
  input  logic                       data_start,
  input  logic                       data_write,
  input  ptr_t                       data_addr,
  input  word_t                      data_wr,
  output logic                       data_ready,
  output word_t                      data_rd,
  core_mem_arbiter_if.master         bus
);

  arb_state_t state;
  grant_t     last_grant;
  logic       granted_once;

  mem_req_t insn_in;
  mem_req_t data_in;
  logic     insn_cand;
  logic     data_cand;
  mem_req_t insn_cand_req;
  mem_req_t data_cand_req;

  logic     accept;
  logic     insn_clear;
  logic     data_clear;
  logic     tie_data;
  logic     issue;
  logic     issue_data;
  mem_req_t next_req;

  assign insn_in = '{addr: insn_addr, write: 1'b0, data: '0};
  assign data_in = '{addr: data_addr, write: data_write, data: data_wr};

  assign accept     = (state != ARB_IDLE) && !bus.bus_waitrequest;
  assign insn_clear = (state == ARB_FETCH) && accept;
  assign data_clear = (state == ARB_DATA) && accept;

  core_mem_arbiter_slot u_insn_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (insn_start),
    .req_in   (insn_in),
    .clear    (insn_clear),
    .cand     (insn_cand),
    .cand_req (insn_cand_req)
  );

  core_mem_arbiter_slot u_data_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (data_start),
    .req_in   (data_in),
    .clear    (data_clear),
    .cand     (data_cand),
    .cand_req (data_cand_req)
  );

  // Until the first grant the fair rule has no history, so DATA_FIRST decides.
  assign tie_data = (FAIR && granted_once) ? (last_grant == GRANT_FETCH) : DATA_FIRST;

  always_comb begin
    issue      = 1'b0;
    issue_data = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        issue      = insn_cand | data_cand;
        issue_data = data_cand && (!insn_cand || tie_data);
      end
      ARB_FETCH: begin
        issue      = accept && data_cand;
        issue_data = 1'b1;
      end
      ARB_DATA: begin
        issue      = accept && insn_cand;
        issue_data = 1'b0;
      end
      default: begin
        issue      = 1'b0;
        issue_data = 1'b0;
      end
    endcase
    next_req = issue_data ? data_cand_req : insn_cand_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB_IDLE;
      last_grant     <= GRANT_FETCH;
      granted_once   <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_read   <= 1'b0;
      bus.bus_write  <= 1'b0;
      bus.bus_wrdata <= '0;
      insn_ready     <= 1'b0;
      insn_data      <= '0;
      data_ready     <= 1'b0;
      data_rd        <= '0;
    end else begin
      insn_ready <= 1'b0;
      data_ready <= 1'b0;

      if (accept) begin
        bus.bus_read  <= 1'b0;
        bus.bus_write <= 1'b0;
        state         <= ARB_IDLE;
        if (state == ARB_FETCH) begin
          insn_ready <= 1'b1;
          insn_data  <= bus.bus_rddata;
        end else begin
          data_ready <= 1'b1;
          // Stores leave the last load value visible.
          if (!bus.bus_write) begin
            data_rd <= bus.bus_rddata;
          end
        end
      end

      // Issue overrides the deassert above so the next command follows with no bubble.
      if (issue) begin
        bus.bus_addr   <= byte_addr(next_req.addr);
        bus.bus_read   <= !next_req.write;
        bus.bus_write  <= next_req.write;
        bus.bus_wrdata <= next_req.data;
        state          <= issue_data ? ARB_DATA : ARB_FETCH;
        last_grant     <= issue_data ? GRANT_DATA : GRANT_FETCH;
        granted_once   <= 1'b1;
      end
    end
  end

  a_one_command : assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.bus_read && bus.bus_write)
  ) else $error("core_mem_arbiter: read and write asserted together");

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: one fair and one fixed-priority instance
// driven with identical requests, each with its own small bus responder.
module tb_core_mem_arbiter;
  import core_mem_arbiter_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  insn_start;
  ptr_t  insn_addr;
  logic  data_start;
  logic  data_write;
  ptr_t  data_addr;
  word_t data_wr;

  logic  f_insn_ready, x_insn_ready;
  word_t f_insn_data,  x_insn_data;
  logic  f_data_ready, x_data_ready;
  word_t f_data_rd,    x_data_rd;

  int n_tests = 0;
  int n_fail  = 0;
  int wait_cycles = 0;
  int cnt_f = 0;
  int cnt_x = 0;

  core_mem_arbiter_if bus_f ();
  core_mem_arbiter_if bus_x ();

  core_mem_arbiter #(.FAIR(1'b1), .DATA_FIRST(1'b1)) u_fair (
    .clk        (clk),
    .rst_n      (rst_n),
    .insn_start (insn_start),
    .insn_addr  (insn_addr),
    .insn_ready (f_insn_ready),
    .insn_data  (f_insn_data),
    .data_start (data_start),
    .data_write (data_write),
    .data_addr  (data_addr),
    .data_wr    (data_wr),
    .data_ready (f_data_ready),
    .data_rd    (f_data_rd),
    .bus        (bus_f)
  );

  core_mem_arbiter #(.FAIR(1'b0), .DATA_FIRST(1'b1)) u_fixed (
    .clk        (clk),
    .rst_n      (rst_n),
    .insn_start (insn_start),
    .insn_addr  (insn_addr),
    .insn_ready (x_insn_ready),
    .insn_data  (x_insn_data),
    .data_start (data_start),
    .data_write (data_write),
    .data_addr  (data_addr),
    .data_wr    (data_wr),
    .data_ready (x_data_ready),
    .data_rd    (x_data_rd),
    .bus        (bus_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t mem_word(input word_t a);
    return (a == 32'h0000_0400) ? 32'hE3A0_0001 : ~a;
  endfunction

  // Each responder stalls a command for wait_cycles edges, then accepts it.
  always @(negedge clk) begin
    if (bus_f.bus_read || bus_f.bus_write) begin
      if (cnt_f < wait_cycles) begin
        bus_f.bus_waitrequest = 1'b1;
        cnt_f++;
      end else begin
        bus_f.bus_waitrequest = 1'b0;
        cnt_f = 0;
      end
      bus_f.bus_rddata = mem_word(bus_f.bus_addr);
    end else begin
      bus_f.bus_waitrequest = 1'b0;
      cnt_f = 0;
    end
  end

  always @(negedge clk) begin
    if (bus_x.bus_read || bus_x.bus_write) begin
      if (cnt_x < wait_cycles) begin
        bus_x.bus_waitrequest = 1'b1;
        cnt_x++;
      end else begin
        bus_x.bus_waitrequest = 1'b0;
        cnt_x = 0;
      end
      bus_x.bus_rddata = mem_word(bus_x.bus_addr);
    end else begin
      bus_x.bus_waitrequest = 1'b0;
      cnt_x = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic gf [6];
  logic gx [6];
  int   g_f;
  int   g_x;
  int   n_is;
  int   n_ds;

  initial begin
    rst_n      = 1'b0;
    insn_start = 1'b0;
    insn_addr  = '0;
    data_start = 1'b0;
    data_write = 1'b0;
    data_addr  = '0;
    data_wr    = '0;
    bus_f.bus_waitrequest = 1'b0;
    bus_f.bus_rddata      = '0;
    bus_x.bus_waitrequest = 1'b0;
    bus_x.bus_rddata      = '0;
    tick();
    tick();

    chk("rst_bus_read", bus_f.bus_read, 1'b0);
    chk("rst_bus_addr", bus_f.bus_addr, 32'h0);
    chk("rst_insn_ready", f_insn_ready, 1'b0);
    chk("rst_insn_data", f_insn_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // single fetch, no stall
    insn_addr  = 30'h100;
    insn_start = 1'b1;
    tick();
    insn_start = 1'b0;
    chk("fetch_cmd_read", bus_f.bus_read, 1'b1);
    chk("fetch_cmd_addr", bus_f.bus_addr, 32'h400);
    chk("fetch_cmd_nowrite", bus_f.bus_write, 1'b0);
    tick();
    chk("fetch_ready", f_insn_ready, 1'b1);
    chk("fetch_data", f_insn_data, 32'hE3A0_0001);
    chk("fetch_bus_idle", bus_f.bus_read, 1'b0);
    tick();
    chk("fetch_ready_once", f_insn_ready, 1'b0);

    // store with three stall cycles
    wait_cycles = 3;
    data_addr  = 30'h10;
    data_write = 1'b1;
    data_wr    = 32'hDEAD_BEEF;
    data_start = 1'b1;
    tick();
    data_start = 1'b0;
    data_write = 1'b0;
    data_wr    = '0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("store_write_%0d", i), bus_f.bus_write, 1'b1);
      chk($sformatf("store_addr_%0d", i), bus_f.bus_addr, 32'h40);
      chk($sformatf("store_wrdata_%0d", i), bus_f.bus_wrdata, 32'hDEAD_BEEF);
      chk($sformatf("store_noready_%0d", i), f_data_ready, 1'b0);
      tick();
    end
    chk("store_ready", f_data_ready, 1'b1);
    chk("store_bus_idle", bus_f.bus_write, 1'b0);
    chk("store_data_rd_kept", f_data_rd, 32'h0);
    tick();
    chk("store_ready_once", f_data_ready, 1'b0);
    wait_cycles = 0;

    // simultaneous starts after reset: data first, fetch with no bubble
    do_reset();
    insn_addr  = 30'h1;
    data_addr  = 30'h2;
    insn_start = 1'b1;
    data_start = 1'b1;
    tick();
    insn_start = 1'b0;
    data_start = 1'b0;
    chk("tie_first_addr", bus_f.bus_addr, 32'h8);
    chk("tie_first_addr_fixed", bus_x.bus_addr, 32'h8);
    tick();
    chk("tie_data_ready", f_data_ready, 1'b1);
    chk("tie_data_rd", f_data_rd, 32'hFFFF_FFF7);
    chk("tie_second_read", bus_f.bus_read, 1'b1);
    chk("tie_second_addr", bus_f.bus_addr, 32'h4);
    tick();
    chk("tie_insn_ready", f_insn_ready, 1'b1);
    chk("tie_insn_data", f_insn_data, 32'hFFFF_FFFB);
    chk("tie_data_ready_low", f_data_ready, 1'b0);
    chk("tie_bus_idle", bus_f.bus_read, 1'b0);

    // continuous contention: each port restarts on its ready
    insn_addr  = 30'h20;
    data_addr  = 30'h30;
    insn_start = 1'b1;
    data_start = 1'b1;
    n_is = 1;
    n_ds = 1;
    g_f  = 0;
    g_x  = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus_f.bus_read && g_f < 6) begin
        gf[g_f] = (bus_f.bus_addr == 32'hC0);
        g_f++;
      end
      if (bus_x.bus_read && g_x < 6) begin
        gx[g_x] = (bus_x.bus_addr == 32'hC0);
        g_x++;
      end
      insn_start = f_insn_ready && (n_is < 3);
      if (insn_start) n_is++;
      data_start = f_data_ready && (n_ds < 3);
      if (data_start) n_ds++;
    end
    insn_start = 1'b0;
    data_start = 1'b0;
    chk("contend_count_fair", g_f, 6);
    chk("contend_count_fixed", g_x, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("contend_fair_g%0d", i), gf[i], (i % 2) == 0);
      chk($sformatf("contend_fixed_g%0d", i), gx[i], (i % 2) == 0);
    end

    // data alone, then a tie: fair grants fetch, fixed grants data
    data_start = 1'b1;
    tick();
    data_start = 1'b0;
    tick();
    chk("prio_data_ready", f_data_ready, 1'b1);
    insn_start = 1'b1;
    data_start = 1'b1;
    tick();
    insn_start = 1'b0;
    data_start = 1'b0;
    chk("prio_fair_first", bus_f.bus_addr, 32'h80);
    chk("prio_fixed_first", bus_x.bus_addr, 32'hC0);
    tick();
    chk("prio_fair_second", bus_f.bus_addr, 32'hC0);
    chk("prio_fixed_second", bus_x.bus_addr, 32'h80);
    tick();
    tick();
    chk("prio_fair_idle", bus_f.bus_read, 1'b0);

    // reset during a stalled fetch
    wait_cycles = 10;
    insn_addr   = 30'h5;
    insn_start  = 1'b1;
    tick();
    insn_start = 1'b0;
    chk("rstmid_cmd_addr", bus_f.bus_addr, 32'h14);
    tick();
    tick();
    chk("rstmid_still_read", bus_f.bus_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_read", bus_f.bus_read, 1'b0);
    chk("rstmid_addr", bus_f.bus_addr, 32'h0);
    chk("rstmid_insn_data", f_insn_data, 32'h0);
    chk("rstmid_data_rd", f_data_rd, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles = 0;
    tick();
    chk("rstmid_no_ready", f_insn_ready, 1'b0);
    insn_addr  = 30'h100;
    insn_start = 1'b1;
    tick();
    insn_start = 1'b0;
    chk("rstmid_new_addr", bus_f.bus_addr, 32'h400);
    tick();
    chk("rstmid_new_ready", f_insn_ready, 1'b1);
    chk("rstmid_new_data", f_insn_data, 32'hE3A0_0001);

    // back-to-back fetch: new start in the ready cycle
    insn_addr  = 30'h101;
    insn_start = 1'b1;
    tick();
    insn_start = 1'b0;
    chk("b2b_ready_low", f_insn_ready, 1'b0);
    chk("b2b_read", bus_f.bus_read, 1'b1);
    chk("b2b_addr", bus_f.bus_addr, 32'h404);
    tick();
    chk("b2b_ready", f_insn_ready, 1'b1);
    chk("b2b_data", f_insn_data, 32'hFFFF_FBFB);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the single external memory bus between the instruction fetch port and the core's load/store data port (mem_addr/mem_start/mem_write/mem_ready).
- Each requester issues one-cycle start pulses with word addresses. The arbiter latches the pulses, selects a winner, runs one bus transaction at a time, and returns a one-cycle ready pulse with read data to the winning port.
- Sits between the core (fetch unit and core_control) and the Avalon-style bus master interface.

Parameters:
FAIR, 1, 1: when both ports are pending, grant the port that did not win the previous grant; 0: fixed priority.
DATA_FIRST, 1, fixed-priority winner and first-grant tie-break: 1 = data port, 0 = fetch port.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
insn_start  in  1  fetch request pulse
insn_addr  in  30  fetch word address (ptr)
insn_ready  out  1  fetch completion pulse
insn_data  out  32  fetched word, valid while insn_ready
data_start  in  1  load/store request pulse
data_write  in  1  1 = store, sampled with data_start
data_addr  in  30  data word address (ptr)
data_wr  in  32  store data, sampled with data_start
data_ready  out  1  data completion pulse
data_rd  out  32  load data, valid while data_ready
bus_addr  out  32  byte address, {ptr, 2'b00}
bus_read  out  1  bus read command
bus_write  out  1  bus write command
bus_wrdata  out  32  bus write data
bus_rddata  in  32  bus read data, valid on the accepting cycle
bus_waitrequest  in  1  bus stall; command accepted on a clock edge where it is low

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE; pending flags cleared; all outputs 0, including bus_addr, insn_data, data_rd; last-grant register = fetch (so the first tie goes to DATA_FIRST's choice). In-flight transactions and pending requests are dropped with no ready pulse. Deassertion is synchronous to clk.
- Request capture: on the edge where a start is sampled, that port's addr, write flag and write data go into its pending slot.
  - A start on a port whose slot is already pending or granted is a protocol violation: ignored, simulation assertion fires.
  - A start in the same cycle that port's ready pulses is legal.
- FSM states: IDLE, FETCH, DATA.
- IDLE: at the edge, candidates are the pending slots plus any start sampled at that edge.
  - If any candidate exists, choose a winner per the FAIR/DATA_FIRST rules and register bus_addr, bus_read/bus_write and bus_wrdata. Commands are asserted the cycle after the start edge.
  - Go to FETCH or DATA.
- FETCH/DATA: hold all bus outputs stable while bus_waitrequest is high; no timeout.
  - At the edge where bus_waitrequest is low: deassert the command, register bus_rddata into insn_data or data_rd, pulse that port's ready for exactly one cycle, and clear its pending slot.
  - If the other slot is pending at that edge, or a start was sampled there, issue its command immediately after the same edge (no idle bubble) and enter the corresponding state. Otherwise return to IDLE.
- Stores still pulse data_ready; data_rd keeps its previous value.
- Minimum latency from start edge to ready: 2 cycles (command cycle, then ready cycle).
- Fairness: FAIR=1 means alternating grants under continuous contention. A waiting port is served at most one transaction later.
- bus_read and bus_write are never both high; at most one transaction is outstanding.

Decomposition:
- Shared core/uarch.sv gets the arbiter state typedef (ARB_IDLE/ARB_FETCH/ARB_DATA) and a mem_req struct {ptr addr; logic write; word data}.
- Natural sub-module core_mem_arbiter_slot: one pending-request register, with capture, clear and protocol-violation assertion. Instantiated once per port.

Test Plan:
- Single fetch: insn_start, insn_addr=30'h100, waitrequest low, rddata=32'hE3A00001 -> bus_read with bus_addr=32'h400 one cycle after start; insn_ready pulses for one cycle with insn_data=32'hE3A00001; bus idle afterwards.
- Store with 3 wait cycles: data_start, data_write=1, data_addr=30'h10, data_wr=32'hDEADBEEF -> bus_write held 4 cycles at 32'h40 with stable data; data_ready pulses once, 5 cycles after the start edge.
- Simultaneous starts, FAIR=1, DATA_FIRST=1, insn_addr=30'h1, data_addr=30'h2 -> data transaction first (bus_addr=32'h8); fetch follows with no bubble (bus_addr=32'h4); ready pulses are one cycle apart.
- Continuous contention, FAIR=1: both ports restart on every ready -> grants alternate D,F,D,F. With FAIR=0, data wins on every contended grant.
- rst_n asserted mid-transaction while waitrequest is high -> all outputs 0 immediately, no ready pulse; after release, a new fetch completes normally.
- Back-to-back fetch, with a start issued in the same cycle insn_ready pulses -> the new request is accepted and its command is issued on the following edge.
